// File: rtl/bsg_counter_load_down_en.sv
// rtl/bsg_counter_load_down_en.sv - loadable down-counter with done pulse, abort and auto-reload
module bsg_counter_load_down_en #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_v_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               load_ready_o,
  input  logic               en_i,
  input  logic               reload_i,
  input  logic               abort_i,
  output logic [width_p-1:0] count_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [width_p-1:0] one_lp = width_p'(1);

  state_e             state_r, state_n;
  logic [width_p-1:0] count_r, count_n;
  logic [width_p-1:0] reload_r, reload_n;
  logic               done_r, done_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      count_r  <= '0;
      reload_r <= '0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      count_r  <= count_n;
      reload_r <= reload_n;
      done_r   <= done_n;
    end
  end

  // Count is never zero in RUN, so "not above one" is the terminal decrement.
  always_comb begin
    state_n  = state_r;
    count_n  = count_r;
    reload_n = reload_r;
    done_n   = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (load_v_i) begin
          reload_n = load_val_i;
          count_n  = load_val_i;
          if (load_val_i != '0) state_n = RUN;
          else                  done_n  = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          count_n = '0;
          state_n = IDLE;
        end else if (en_i) begin
          if (count_r > one_lp) begin
            count_n = count_r - one_lp;
          end else begin
            done_n = 1'b1;
            if (reload_i) begin
              count_n = reload_r;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign count_o      = count_r;
  assign done_o       = done_r;
  assign busy_o       = (state_r == RUN);
  assign load_ready_o = (state_r == IDLE);

endmodule

// File: tb/tb_bsg_counter_load_down_en.sv
// tb/tb_bsg_counter_load_down_en.sv - scoreboard bench for bsg_counter_load_down_en at width 3
module tb_bsg_counter_load_down_en;

  localparam int W = 3;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         load_v_i;
  logic [W-1:0] load_val_i;
  logic         load_ready_o;
  logic         en_i;
  logic         reload_i;
  logic         abort_i;
  logic [W-1:0] count_o;
  logic         busy_o;
  logic         done_o;

  bsg_counter_load_down_en #(.width_p(W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .load_v_i(load_v_i), .load_val_i(load_val_i),
    .load_ready_o(load_ready_o), .en_i(en_i), .reload_i(reload_i), .abort_i(abort_i),
    .count_o(count_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0] count;
    logic         done;
    logic         busy;
    logic         ready;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state of the countdown as the bench expects it.
  bit         m_run;
  bit [W-1:0] m_cnt;
  bit [W-1:0] m_rl;
  bit         m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_rl = 0; m_done = 0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
  task automatic step(input bit lv, input bit [W-1:0] val, input bit en, input bit rl, input bit ab);
    exp_t e;
    exp_t got;
    @(negedge clk_i);
    load_v_i = lv; load_val_i = val; en_i = en; reload_i = rl; abort_i = ab;
    m_done = 0;
    if (!m_run) begin
      if (lv) begin
        m_rl = val;
        m_cnt = val;
        if (val == 0) m_done = 1;
        else          m_run  = 1;
      end
    end else if (ab) begin
      m_cnt = 0; m_run = 0;
    end else if (en) begin
      if (m_cnt >= 2) m_cnt = m_cnt - 1;
      else begin
        m_done = 1;
        if (rl) m_cnt = m_rl;
        else begin m_cnt = 0; m_run = 0; end
      end
    end
    e.count = m_cnt; e.done = m_done; e.busy = m_run; e.ready = !m_run;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    got = {count_o, done_o, busy_o, load_ready_o};
    check("sb_outputs", 32'(got), 32'(e));
  endtask

  int dones;

  initial begin
    reset_n_i = 1'b0; load_v_i = 0; load_val_i = 0; en_i = 0; reload_i = 0; abort_i = 0;
    model_reset();
    #12;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(load_ready_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(0, 0, 1, 1, 1);

    // Basic countdown from 5 with enable held.
    step(1, 5, 1, 0, 0);
    check("basic_t1", 32'(count_o), 32'd5);
    check("basic_rdy_low", 32'(load_ready_o), 32'd0);
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 1, 0, 0);
      check("basic_seq", 32'(count_o), 32'(i));
      check("basic_nodone", 32'(done_o), 32'd0);
    end
    step(0, 0, 1, 0, 0);
    check("basic_zero", 32'(count_o), 32'd0);
    check("basic_done", 32'(done_o), 32'd1);
    check("basic_idle", 32'(busy_o), 32'd0);

    // Back-to-back: load presented during the done cycle, then enable gaps.
    step(1, 3, 1, 0, 0);
    check("b2b_loaded", 32'(count_o), 32'd3);
    check("b2b_busy", 32'(busy_o), 32'd1);
    step(0, 0, 0, 0, 0);
    check("gap_hold", 32'(count_o), 32'd3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("gap_hold2", 32'(count_o), 32'd2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("gap_done", 32'(done_o), 32'd1);

    // Abort together with enable at count 2.
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("abort_pre", 32'(count_o), 32'd2);
    step(0, 0, 1, 1, 1);
    check("abort_count", 32'(count_o), 32'd0);
    check("abort_nodone", 32'(done_o), 32'd0);
    check("abort_idle", 32'(load_ready_o), 32'd1);

    // Auto-reload: 3,2,1,3,2,1,... then drop reload.
    step(1, 3, 1, 1, 0);
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 1, 0);
      if (done_o) dones++;
      check("reload_busy", 32'(busy_o), 32'd1);
    end
    check("reload_pulses", 32'(dones), 32'd3);
    check("reload_count", 32'(count_o), 32'd3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("reload_end", 32'(count_o), 32'd0);
    check("reload_end_idle", 32'(busy_o), 32'd0);

    // Zero-length and full-range loads; loads while busy are ignored.
    step(1, 0, 1, 0, 0);
    check("zero_done", 32'(done_o), 32'd1);
    check("zero_idle", 32'(busy_o), 32'd0);
    step(1, 7, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 2, 1, 0, 0);
    check("busy_load_ignored", 32'(count_o), 32'd1);
    step(0, 0, 1, 0, 0);
    check("full_done", 32'(done_o), 32'd1);
    check("full_zero", 32'(count_o), 32'd0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);

    // Asynchronous reset in the middle of a countdown.
    step(0, 0, 0, 0, 1);
    step(1, 6, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_ready", 32'(load_ready_o), 32'd1);
    check("arst_done", 32'(done_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(1, 2, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("post_rst_done", 32'(done_o), 32'd1);
    check("no_x", 32'($isunknown({count_o, done_o, busy_o, load_ready_o})), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bsg_counter_load_down_en.md
Name: bsg_counter_load_down_en

Overview:
- Loadable down-counter / countdown timer. It is the decrementing counterpart of the team's set/enable up-counter.
- A producer loads a start value through a valid/ready handshake. The block then counts down on each enabled cycle to zero and emits a one-cycle done pulse.
- Optional auto-reload turns it into a periodic tick generator.
- Used for credit timeouts, delay stalls and periodic events in bsg-style control paths.

Parameters:
- width_p, 8, width of the counter and of the load value (unsigned). Legal range is 1 or greater.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  reset, asynchronous and active-low.
- load_v_i  input  1  load request valid.
- load_val_i  input  width_p  start value; sampled when the load handshake fires.
- load_ready_o  output  1  block can accept a load. High exactly when in IDLE.
- en_i  input  1  count enable; decrement permitted this cycle.
- reload_i  input  1  auto-reload request; sampled only on a terminal decrement.
- abort_i  input  1  cancel an in-progress countdown.
- count_o  output  width_p  current count value (registered).
- busy_o  output  1  high while in RUN.
- done_o  output  1  registered one-cycle pulse marking countdown completion.

Behaviour:
- Reset values:
  - reset_n_i=0 asynchronously forces state=IDLE, count_o=0, reload register=0, done_o=0, busy_o=0, load_ready_o=1.
  - Deassertion takes effect at the next clock edge.
- States: IDLE and RUN. busy_o = (state==RUN). load_ready_o = (state==IDLE).
- done_o defaults to 0 every cycle unless set by one of the rules below.
- IDLE:
  - Load fires when load_v_i & load_ready_o. The reload register is loaded with load_val_i.
  - If load_val_i != 0: count_o <= load_val_i, next state RUN.
  - If load_val_i == 0: count_o <= 0, done_o <= 1, stay IDLE (zero-length countdown).
  - en_i, reload_i and abort_i are ignored in IDLE.
- RUN, evaluated with this priority:
  - abort_i=1: count_o <= 0, next IDLE, no done pulse. Abort beats en_i in the same cycle.
  - en_i=0: hold count_o and state.
  - en_i=1 and count_o > 1: count_o <= count_o - 1.
  - en_i=1 and count_o == 1 (terminal decrement):
    - done_o <= 1.
    - If reload_i=1: count_o <= reload register, stay RUN. The count never shows 0 in this case.
    - Otherwise: count_o <= 0, next IDLE.
- Latency: load of N>0 accepted at cycle t with en_i held high:
  - count_o = N at t+1, N-1 at t+2, and so on.
  - count_o = 0, done_o = 1, busy_o = 0 and load_ready_o = 1 all occur at t+N+1.
  - A load of 0 gives done_o at t+1.
- Back-to-back: a new load may be accepted in the same cycle done_o is high, since state is IDLE in that cycle.
- Arithmetic: unsigned, width_p bits. count_o is nonzero whenever the state is RUN, so no underflow or wrap can occur.
- The maximum load value 2^width_p - 1 counts the full range.
- reload_i sampled on a non-terminal decrement has no effect.
- Mid-operation reset: asserting reset_n_i in RUN immediately returns to the reset values. No done pulse is produced.
- No X on outputs after reset.

Test Plan:
- Basic countdown:
  - Stimulus: reset, then load 5 with en_i=1 continuously.
  - Required: count_o sequence 5,4,3,2,1,0; done_o=1 only in the cycle count_o becomes 0 (t+6); load_ready_o low for t+1..t+5.
- Enable gaps and abort:
  - Stimulus: load 3, en_i toggling 1,0,1,0.
  - Required: count_o holds on en_i=0 cycles and done arrives at the 3rd enabled cycle +1.
  - Stimulus: load 4, raise abort_i together with en_i at count 2.
  - Required: count_o=0, IDLE, no done_o.
- Auto-reload:
  - Stimulus: load 3, en_i=1, reload_i=1.
  - Required: count_o 3,2,1,3,2,1…; done_o pulses every 3 cycles; busy_o stays 1.
  - Stimulus: drop reload_i before the next terminal decrement.
  - Required: counter ends at 0 and returns to IDLE.
- Edge values (width_p=3):
  - Stimulus: load 0. Required: done_o at t+1 and state stays IDLE.
  - Stimulus: load 7. Required: 7..0 with done_o at t+8.
  - Stimulus: load_v_i while busy. Required: ignored and count unaffected.
- Back-to-back and reset:
  - Stimulus: new load presented in the done_o cycle. Required: accepted and the new countdown starts next cycle.
  - Stimulus: assert reset_n_i=0 asynchronously mid-RUN, between clock edges. Required: count_o=0, busy_o=0, load_ready_o=1 immediately.
